// File: rtl/sr_flop_bank.sv
// Bank of WIDTH independent SR flops with a selectable s=r=1 resolution,
// per-channel conflict flags, a sticky error flag and a saturating conflict counter.
module sr_flop_bank #(
  parameter int unsigned WIDTH         = 8,
  parameter int unsigned CONFLICT_MODE = 0,
  parameter int unsigned CNT_W         = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] r,
  input  logic             clear_err,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb,
  output logic [WIDTH-1:0] conflict,
  output logic             err,
  output logic [CNT_W-1:0] err_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] both_c;
  logic [WIDTH-1:0] plain_c;
  logic [WIDTH-1:0] conf_val_c;
  logic [WIDTH-1:0] q_next_c;
  logic             any_conf_c;
  logic [CNT_W-1:0] cnt_inc_c;

  assign both_c     = s & r;
  assign any_conf_c = enable & (|both_c);
  assign cnt_inc_c  = (err_count == CNT_MAX) ? CNT_MAX : err_count + CNT_W'(1);

  // Next channel state: plain SR for non-conflicting bits, mode-selected value otherwise
  always_comb begin
    plain_c    = (q | s) & ~r;
    conf_val_c = q;
    case (CONFLICT_MODE)
      0:       conf_val_c = q;
      1:       conf_val_c = '1;
      2:       conf_val_c = '0;
      default: conf_val_c = ~q;
    endcase
    q_next_c = (plain_c & ~both_c) | (conf_val_c & both_c);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q        <= '0;
      qb       <= '1;
      conflict <= '0;
    end else if (enable) begin
      q        <= q_next_c;
      qb       <= ~q_next_c;
      conflict <= both_c;
    end else begin
      conflict <= '0;
    end
  end

  // A conflict in the same cycle as clear_err restarts the count at one
  always_ff @(posedge clk) begin
    if (reset) begin
      err       <= 1'b0;
      err_count <= '0;
    end else if (any_conf_c) begin
      err       <= 1'b1;
      err_count <= clear_err ? CNT_W'(1) : cnt_inc_c;
    end else if (clear_err) begin
      err       <= 1'b0;
      err_count <= '0;
    end
  end

endmodule

// File: tb/tb_sr_flop_bank.sv
// Directed bench for sr_flop_bank: four conflict-mode instances plus a 2-bit counter instance share stimulus.
module tb_sr_flop_bank;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [7:0] s;
  logic [7:0] r;
  logic       clear_err;

  logic [7:0] q0, qb0, cf0;  logic e0;  logic [7:0] c0;
  logic [7:0] q1, qb1, cf1;  logic e1;  logic [7:0] c1;
  logic [7:0] q2, qb2, cf2;  logic e2;  logic [7:0] c2;
  logic [7:0] q3, qb3, cf3;  logic e3;  logic [7:0] c3;
  logic [7:0] qs, qbs, cfs;  logic es;  logic [1:0] cs;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sr_flop_bank #(.WIDTH(8), .CONFLICT_MODE(0), .CNT_W(8)) u_m0 (
    .clk(clk), .reset(reset), .enable(enable), .s(s), .r(r), .clear_err(clear_err),
    .q(q0), .qb(qb0), .conflict(cf0), .err(e0), .err_count(c0));
  sr_flop_bank #(.WIDTH(8), .CONFLICT_MODE(1), .CNT_W(8)) u_m1 (
    .clk(clk), .reset(reset), .enable(enable), .s(s), .r(r), .clear_err(clear_err),
    .q(q1), .qb(qb1), .conflict(cf1), .err(e1), .err_count(c1));
  sr_flop_bank #(.WIDTH(8), .CONFLICT_MODE(2), .CNT_W(8)) u_m2 (
    .clk(clk), .reset(reset), .enable(enable), .s(s), .r(r), .clear_err(clear_err),
    .q(q2), .qb(qb2), .conflict(cf2), .err(e2), .err_count(c2));
  sr_flop_bank #(.WIDTH(8), .CONFLICT_MODE(3), .CNT_W(8)) u_m3 (
    .clk(clk), .reset(reset), .enable(enable), .s(s), .r(r), .clear_err(clear_err),
    .q(q3), .qb(qb3), .conflict(cf3), .err(e3), .err_count(c3));
  sr_flop_bank #(.WIDTH(8), .CONFLICT_MODE(0), .CNT_W(2)) u_sat (
    .clk(clk), .reset(reset), .enable(enable), .s(s), .r(r), .clear_err(clear_err),
    .q(qs), .qb(qbs), .conflict(cfs), .err(es), .err_count(cs));

  task automatic step(input logic rst, input logic en, input logic [7:0] sv,
                      input logic [7:0] rv, input logic clr);
    reset = rst; enable = en; s = sv; r = rv; clear_err = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    step(1'b1, 1'b1, 8'hFF, 8'h00, 1'b0);
    checks++;
    if (q0 !== 8'h00 || qb0 !== 8'hFF || cf0 !== 8'h00 || e0 !== 1'b0 || c0 !== 8'h00) begin
      failures++;
      $display("FAIL reset_m0: q=%h qb=%h conf=%h err=%b cnt=%0d, want 00 ff 00 0 0", q0, qb0, cf0, e0, c0);
    end
    checks++;
    if (q3 !== 8'h00 || qb3 !== 8'hFF || qs !== 8'h00 || cs !== 2'd0) begin
      failures++;
      $display("FAIL reset_others: q3=%h qb3=%h qs=%h cs=%0d, want 00 ff 00 0", q3, qb3, qs, cs);
    end
  endtask

  task automatic test_basic();
    logic [7:0] exp_q[3] = '{8'h0F, 8'h0C, 8'h0C};
    logic [7:0] sv[3] = '{8'h0F, 8'h00, 8'h00};
    logic [7:0] rv[3] = '{8'h00, 8'h03, 8'h00};
    step(1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, sv[i], rv[i], 1'b0);
      checks++;
      if (q0 !== exp_q[i] || qb0 !== ~exp_q[i] || cf0 !== 8'h00 || e0 !== 1'b0) begin
        failures++;
        $display("FAIL basic_%0d: q=%h qb=%h conf=%h err=%b, want q=%h qb=%h conf=00 err=0",
                 i, q0, qb0, cf0, e0, exp_q[i], ~exp_q[i]);
      end
    end
  endtask

  task automatic test_modes();
    step(1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
    step(1'b0, 1'b1, 8'hAA, 8'h55, 1'b0);
    checks++;
    if (q0 !== 8'hAA || q1 !== 8'hAA || q2 !== 8'hAA || q3 !== 8'hAA) begin
      failures++;
      $display("FAIL modes_preload: q0=%h q1=%h q2=%h q3=%h, want aa", q0, q1, q2, q3);
    end
    step(1'b0, 1'b1, 8'hFF, 8'hFF, 1'b0);
    checks++;
    if (q0 !== 8'hAA || q1 !== 8'hFF || q2 !== 8'h00 || q3 !== 8'h55) begin
      failures++;
      $display("FAIL modes_q: q0=%h q1=%h q2=%h q3=%h, want aa ff 00 55", q0, q1, q2, q3);
    end
    checks++;
    if (qb0 !== 8'h55 || qb1 !== 8'h00 || qb2 !== 8'hFF || qb3 !== 8'hAA) begin
      failures++;
      $display("FAIL modes_qb: qb0=%h qb1=%h qb2=%h qb3=%h, want 55 00 ff aa", qb0, qb1, qb2, qb3);
    end
    checks++;
    if (cf0 !== 8'hFF || cf3 !== 8'hFF || e0 !== 1'b1 || c0 !== 8'd1 || e2 !== 1'b1 || c2 !== 8'd1) begin
      failures++;
      $display("FAIL modes_err: conf=%h conf3=%h err=%b cnt=%0d err2=%b cnt2=%0d, want ff ff 1 1 1 1",
               cf0, cf3, e0, c0, e2, c2);
    end
  endtask

  task automatic test_enable_gating();
    step(1'b0, 1'b1, 8'h3C, 8'hC3, 1'b0);
    checks++;
    if (q0 !== 8'h3C || q3 !== 8'h3C || cf0 !== 8'h00 || c0 !== 8'd1) begin
      failures++;
      $display("FAIL gate_preload: q0=%h q3=%h conf=%h cnt=%0d, want 3c 3c 00 1", q0, q3, cf0, c0);
    end
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 8'hFF, 8'hFF, 1'b0);
      checks++;
      if (q0 !== 8'h3C || qb0 !== 8'hC3 || q1 !== 8'h3C || q3 !== 8'h3C ||
          cf0 !== 8'h00 || e0 !== 1'b1 || c0 !== 8'd1) begin
        failures++;
        $display("FAIL gate_%0d: q0=%h qb0=%h q1=%h q3=%h conf=%h err=%b cnt=%0d, want 3c c3 3c 3c 00 1 1",
                 i, q0, qb0, q1, q3, cf0, e0, c0);
      end
    end
  endtask

  task automatic test_saturation();
    logic [1:0] exp_s[5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    step(1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, 8'h01, 8'h01, 1'b0);
      checks++;
      if (cs !== exp_s[i] || es !== 1'b1 || c0 !== 8'(i + 1)) begin
        failures++;
        $display("FAIL sat_%0d: cnt2=%0d err=%b cnt8=%0d, want %0d 1 %0d", i, cs, es, c0, exp_s[i], i + 1);
      end
    end
    step(1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
    checks++;
    if (cs !== 2'd0 || es !== 1'b0 || c0 !== 8'd0 || e0 !== 1'b0) begin
      failures++;
      $display("FAIL sat_clear: cnt2=%0d err=%b cnt8=%0d err8=%b, want 0 0 0 0", cs, es, c0, e0);
    end
  endtask

  task automatic test_clear_collision();
    step(1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
    step(1'b0, 1'b1, 8'h80, 8'h00, 1'b0);
    step(1'b0, 1'b1, 8'h01, 8'h01, 1'b0);
    step(1'b0, 1'b1, 8'h01, 8'h01, 1'b0);
    checks++;
    if (c0 !== 8'd2) begin
      failures++;
      $display("FAIL collide_pre: cnt=%0d, want 2", c0);
    end
    step(1'b0, 1'b1, 8'h01, 8'h01, 1'b1);
    checks++;
    if (e0 !== 1'b1 || c0 !== 8'd1 || cf0 !== 8'h01 || q0 !== 8'h80) begin
      failures++;
      $display("FAIL collide: err=%b cnt=%0d conf=%h q=%h, want 1 1 01 80", e0, c0, cf0, q0);
    end
    step(1'b0, 1'b0, 8'hFF, 8'h00, 1'b1);
    checks++;
    if (e0 !== 1'b0 || c0 !== 8'd0 || q0 !== 8'h80 || qb0 !== 8'h7F || cf0 !== 8'h00) begin
      failures++;
      $display("FAIL clear_only: err=%b cnt=%0d q=%h qb=%h conf=%h, want 0 0 80 7f 00", e0, c0, q0, qb0, cf0);
    end
  endtask

  task automatic test_reset_mid();
    step(1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
    step(1'b0, 1'b1, 8'hFF, 8'h00, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'hFF, 8'hFF, 1'b0);
    checks++;
    if (q0 !== 8'hFF || c0 !== 8'd3) begin
      failures++;
      $display("FAIL rstmid_pre: q=%h cnt=%0d, want ff 3", q0, c0);
    end
    step(1'b1, 1'b1, 8'hFF, 8'hFF, 1'b1);
    checks++;
    if (q0 !== 8'h00 || qb0 !== 8'hFF || cf0 !== 8'h00 || e0 !== 1'b0 || c0 !== 8'd0 ||
        q1 !== 8'h00 || cf3 !== 8'h00 || cs !== 2'd0) begin
      failures++;
      $display("FAIL rstmid: q=%h qb=%h conf=%h err=%b cnt=%0d q1=%h conf3=%h cnt2=%0d, want 00 ff 00 0 0 00 00 0",
               q0, qb0, cf0, e0, c0, q1, cf3, cs);
    end
    step(1'b0, 1'b1, 8'h81, 8'h00, 1'b0);
    checks++;
    if (q0 !== 8'h81 || qb0 !== 8'h7E || e0 !== 1'b0) begin
      failures++;
      $display("FAIL post_reset: q=%h qb=%h err=%b, want 81 7e 0", q0, qb0, e0);
    end
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; s = '0; r = '0; clear_err = 1'b0;
    test_reset();
    test_basic();
    test_modes();
    test_enable_gating();
    test_saturation();
    test_clear_collision();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sr_flop_bank.md
SR_FLOP_BANK -- requirements
Module: sr_flop_bank

Interface
REQ-001 The block SHALL take parameter WIDTH, default 8: number of independent SR channels, legal range 1 to 32.
REQ-002 The block SHALL take parameter CONFLICT_MODE, default 0: resolution when s=r=1; 0 hold, 1 set wins, 2 reset wins, 3 toggle.
REQ-003 The block SHALL take parameter CNT_W, default 8: width of the conflict counter, legal range 2 to 16.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port enable, input, 1 bit: when high, s and r are sampled this cycle.
REQ-007 The block SHALL have port s, input, WIDTH bits: per-channel set request.
REQ-008 The block SHALL have port r, input, WIDTH bits: per-channel reset request.
REQ-009 The block SHALL have port clear_err, input, 1 bit: clears err and err_count.
REQ-010 The block SHALL have port q, output, WIDTH bits, registered: channel state.
REQ-011 The block SHALL have port qb, output, WIDTH bits, registered: complement of q.
REQ-012 The block SHALL have port conflict, output, WIDTH bits, registered: channels that saw s=r=1 in the last enabled cycle.
REQ-013 The block SHALL have port err, output, 1 bit, registered: sticky flag, any conflict since the last clear.
REQ-014 The block SHALL have port err_count, output, CNT_W bits, registered: saturating count of cycles containing a conflict.

Function
REQ-015 Every output SHALL change only on the rising edge of clk, with 1-cycle latency from sampled inputs.
REQ-016 With enable=1, channel i SHALL set q[i]=1 for s=1,r=0, clear q[i]=0 for s=0,r=1, and hold q[i] for s=0,r=0.
REQ-017 With enable=1 and s[i]=r[i]=1, q[i] SHALL hold (mode 0), become 1 (mode 1), become 0 (mode 2), or invert (mode 3).
REQ-018 qb SHALL equal ~q in every cycle; no output SHALL ever be driven X or Z.
REQ-019 With enable=1, conflict[i] SHALL be set to s[i]&r[i]; with enable=0, conflict SHALL be all zeros.
REQ-020 Any enabled cycle with at least one conflict bit SHALL set err=1 and increment err_count by exactly 1, regardless of how many channels conflict.
REQ-021 err_count SHALL saturate at 2^CNT_W-1 and stay there until cleared or reset; it SHALL NOT wrap.
REQ-022 With enable=0, q, qb, err and err_count SHALL hold; s and r SHALL be ignored.
REQ-023 clear_err=1 SHALL, on the next edge, set err=0 and err_count=0, whether or not enable is high.
REQ-024 If clear_err=1 coincides with an enabled conflict cycle, the conflict SHALL win: err=1 and err_count=1 after the edge.
REQ-025 clear_err SHALL NOT affect q, qb or conflict.

Reset
REQ-026 With reset=1 at a rising edge, the block SHALL set q=0, qb=all ones, conflict=0, err=0 and err_count=0.
REQ-027 Reset SHALL take priority over enable, s, r and clear_err, including during a conflict cycle.
REQ-028 On the first edge after reset deasserts, the block SHALL apply normal function to that cycle's inputs.

Verification
REQ-029 Scenario, basic set/reset/hold: WIDTH=8, mode 0; after reset, enable=1, s=0x0F, r=0x00, then s=0x00, r=0x03, then s=r=0x00 -> q=0x0F, then 0x0C, then stays 0x0C; qb=~q throughout.
REQ-030 Scenario, all four conflict modes: q=0xAA, enable=1, s=r=0xFF -> q=0xAA (mode 0), 0xFF (mode 1), 0x00 (mode 2), 0x55 (mode 3); conflict=0xFF; err=1; err_count=1.
REQ-031 Scenario, enable gating: q=0x3C, enable=0, s=0xFF, r=0xFF for 5 cycles -> q=0x3C, conflict=0x00, err_count unchanged.
REQ-032 Scenario, counter saturation: CNT_W=2, enabled conflicts on 5 consecutive cycles -> err_count=1,2,3,3,3; clear_err -> 0.
REQ-033 Scenario, clear vs conflict collision: err_count=2, clear_err=1 in the same cycle as enabled s=r=0x01 -> err=1, err_count=1.
REQ-034 Scenario, reset mid-operation: q=0xFF, err_count=3, reset=1 with enable=1, s=r=0xFF and clear_err=1 -> q=0x00, qb=0xFF, conflict=0, err=0, err_count=0.
